// File: rtl/pipe_stage_hs_if.sv
// Valid/ready beat bus carrying a datapath bundle and a control bundle between
// two pipeline stages; master drives the beat, slave answers with ready.
interface pipe_stage_hs_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with synchronous flush, optional 2-entry
// skid buffer, bubble-gated control outputs and saturating stall/bubble counters.
module pipe_stage_hs #(
    parameter int DATA_W  = 96,
    parameter int CTRL_W  = 8,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cnt_clr,
    pipe_stage_hs_if.slave    in_bus,
    pipe_stage_hs_if.master   out_bus,
    output logic [CTRL_W-1:0] haz_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    occ_e              state;
    occ_e              state_nxt;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              head_from_in;
    logic              head_from_skid;
    logic              skid_from_in;
    logic              out_valid;
    logic              in_ready;
    logic              push;
    logic              pop;

    assign out_valid = (state != EMPTY);

    // With the skid buffer, ready depends only on registered occupancy, which
    // cuts the combinational path from out_ready back to the upstream stage.
    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready = (state != TWO);
        end else begin : g_noskid
            assign in_ready = (state == EMPTY) | out_bus.ready;
        end
    endgenerate

    assign push = in_bus.valid & in_ready;
    assign pop  = out_valid & out_bus.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        head_from_in   = 1'b0;
        head_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt    = ONE;
                    head_from_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_from_in = 1'b1;
                end else if (push) begin
                    state_nxt    = TWO;
                    skid_from_in = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_from_skid = 1'b1;
                    if (push) begin
                        skid_from_in = 1'b1;
                    end else begin
                        state_nxt = ONE;
                    end
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        // Flush wins over everything, including a same-cycle push.
        if (flush) begin
            state_nxt      = EMPTY;
            head_from_in   = 1'b0;
            head_from_skid = 1'b0;
            skid_from_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (head_from_in) begin
                head_data <= in_bus.data;
                head_ctrl <= in_bus.ctrl;
            end else if (head_from_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
            end
            if (skid_from_in) begin
                skid_data <= in_bus.data;
                skid_ctrl <= in_bus.ctrl;
            end
        end
    end

    // Counters hold at all-ones instead of wrapping; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_bus.ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign in_bus.ready = in_ready;
    assign out_bus.valid = out_valid;
    assign out_bus.data  = head_data;
    assign out_bus.ctrl  = out_valid ? head_ctrl : '0;
    assign haz_ctrl      = out_valid ? head_ctrl : '0;
endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register, the successor to the fixed ID/EX latch.
- Carries a DATA_W datapath bundle and a CTRL_W control bundle between two pipeline stages using valid/ready handshakes instead of a free-running latch.
- Adds synchronous flush, an optional 2-entry skid buffer that breaks the ready path, bubble-gated control outputs for the hazard unit, and saturating stall/bubble performance counters.
- Used for every inter-stage boundary (D->E, E->M, M->W) of the next core revision.

Parameters:
DATA_W, 96, width of datapath bundle (operands, immediate, instruction)
CTRL_W, 8, width of control bundle (regwrite, memtoreg, aluctrl, ...)
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous flush from hazard unit
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_data  in  DATA_W  upstream datapath bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_data  out  DATA_W  head entry datapath
out_ctrl  out  CTRL_W  head entry control, zero when out_valid=0
haz_ctrl  out  CTRL_W  copy of out_ctrl for hazard unit
cnt_clr  in  1  synchronous clear of both counters
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- Events: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (async, rst=1):
  - occupancy 0; all stored data/ctrl 0; out_valid=0; out_data=0; out_ctrl=0; haz_ctrl=0; both counters 0.
  - in_ready = 1 while in reset.
- Storage is strict FIFO order. head = oldest entry. out_data/out_ctrl are driven from head registers; no combinational in->out path.
- Latency: a beat pushed into an empty stage appears on out_valid on the next cycle (1 cycle).
- SKID_EN=1:
  - Occupancy 0..2; in_ready = (occupancy<2), a registered function of state only.
  - push without pop: occupancy+1.
  - pop without push: occupancy-1; skid entry moves to head.
  - push with pop:
    - occupancy 1: the new beat replaces head.
    - occupancy 2: skid moves to head and the new beat enters skid.
  - Full throughput: one beat per cycle while out_ready=1.
- SKID_EN=0:
  - Occupancy 0..1; in_ready = (occupancy==0) | out_ready (combinational).
  - push with pop loads the new beat into head.
- Flush (synchronous, highest priority):
  - At a clock edge with flush=1: occupancy becomes 0, all stored data/ctrl is zeroed, and any same-cycle push is discarded.
  - Outputs in the flush cycle itself are unaffected; a pop occurring in that cycle is a completed transfer.
  - in_ready is 1 the cycle after a flush. Counters are not affected by flush.
- Bubble gating: out_ctrl = haz_ctrl = head ctrl when out_valid=1, else all-zero. Flushed or empty slots never assert control bits.
- Counters:
  - stall_cnt +1 on each cycle with out_valid & ~out_ready; bubble_cnt +1 on each cycle with ~out_valid.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets both to 0 at the edge, taking priority over increment.
- rst asserted mid-transfer discards all entries immediately (asynchronous). No beat may be emitted after rst deasserts until a new push.
- in_valid held with in_ready=0 is legal; the beat is taken on the first cycle in_ready=1.
- in_data and in_ctrl are ignored when in_valid=0.

Test Plan:
- Reset then stream 0x1..0x5 with out_ready=1 held, SKID_EN=1 -> out_data=0x1..0x5 on consecutive cycles starting 1 cycle after first push; bubble_cnt=1 (the first cycle); stall_cnt=0.
- Push 0xA, 0xB, 0xC with out_ready=0 -> in_ready low after 2 pushes; 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order; stall_cnt counts every out_ready=0 cycle while out_valid=1.
- Occupancy 2 (0xA, 0xB), assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, haz_ctrl=0, in_ready=1; 0xC is never output.
- SKID_EN=0, occupancy 1, out_ready=1, in_valid=1 -> in_ready=1 the same cycle and head replaced by the new beat; one beat per cycle sustained.
- CNT_W=4, out_valid=0 for 20 cycles -> bubble_cnt saturates at 15. Pulse cnt_clr during a bubble cycle -> bubble_cnt=0 next cycle.
- Assert rst asynchronously between edges with occupancy 2 -> out_valid, out_ctrl and counters go to 0 immediately. After deassert, no output until a new push.
